// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: sequences a W-bit PS/RL shift register through load, N shifts and a hold.
// Ports: clk/rst (sync, active-high); start/op/amount/data_in command in;
// q register feedback; PS/RL/SIR/SIL/DATA register controls; busy/done handshake.
module shift_seq_ctrl #(
    parameter int W  = 4,
    parameter int AW = $clog2(W) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [AW-1:0] amount,
    input  logic [W-1:0]  data_in,
    input  logic [W-1:0]  q,
    output logic          PS,
    output logic          RL,
    output logic          SIR,
    output logic          SIL,
    output logic [W-1:0]  DATA,
    output logic          busy,
    output logic          done
);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [1:0]      op_q, op_d;
    logic [W-1:0]    data_q, data_d;
    logic            shifting;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            data_q  <= data_d;
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        data_d  = data_q;
        if (state_q == IDLE && start) begin
            state_d = LOAD;
            op_d    = op;
            data_d  = data_in;
            cnt_d   = (amount > AW'(W)) ? AW'(W) : amount;
        end else if (state_q == LOAD) begin
            state_d = (cnt_q != '0) ? SHIFT : DONE;
        end else if (state_q == SHIFT) begin
            cnt_d   = cnt_q - 1'b1;
            state_d = (cnt_q == AW'(1)) ? DONE : SHIFT;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end
    // op[0] selects right shifts; op[1] feeds the MSB back in (ROL on the left, ASR on the right)
    always_comb begin
        shifting = (state_q == SHIFT);
        PS       = !shifting;
        RL       = shifting && op_q[0];
        SIR      = shifting && op_q == 2'b10 && q[W-1];
        SIL      = shifting && op_q == 2'b11 && q[W-1];
        DATA     = (state_q == LOAD) ? data_q : q;
        busy     = (state_q == LOAD) || shifting;
        done     = (state_q == DONE);
    end
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: directed bench for shift_seq_ctrl driving a behavioural 4-bit shift register.
module tb_shift_seq_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] op = '0;
    logic [2:0] amount = '0;
    logic [3:0] data_in = '0;
    logic [3:0] q = '0;
    logic       PS, RL, SIR, SIL, busy, done;
    logic [3:0] DATA;
    int         checks = 0;
    int         failures = 0;

    shift_seq_ctrl #(.W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .amount(amount),
        .data_in(data_in), .q(q), .PS(PS), .RL(RL), .SIR(SIR), .SIL(SIL),
        .DATA(DATA), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk)
        q <= PS ? DATA : (RL ? {SIL, q[3:1]} : {q[2:0], SIR});

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic run(input string tag, input logic [1:0] o, input logic [2:0] a,
                       input logic [3:0] d, input logic [3:0] exp_q, input int exp_lat,
                       input int poke);
        int lat, nbusy, ndone;
        @(negedge clk);
        op = o; amount = a; data_in = d; start = 1'b1;
        @(negedge clk);
        start = 1'b0; op = ~o; amount = 3'd5; data_in = ~d;
        lat = 1;
        nbusy = 0;
        while (!done && lat < 20) begin
            nbusy += int'(busy);
            start = (lat == poke);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_busy"}, nbusy, exp_lat - 1);
        check({tag, "_q"}, int'(q), int'(exp_q));
        ndone = 0;
        repeat (4) begin
            @(negedge clk);
            ndone += int'(done);
        end
        check({tag, "_nodone"}, ndone, 0);
        check({tag, "_hold"}, int'(q), int'(exp_q));
    endtask

    initial begin
        int ndone;
        repeat (2) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_ps", int'(PS), 1);
        check("rst_ctl", int'({RL, SIR, SIL}), 0);
        check("rst_data", int'(DATA), int'(q));
        rst = 1'b0;
        run("lsl1", 2'b00, 3'd1, 4'b1011, 4'b0110, 3, 2);
        repeat (10) begin
            @(negedge clk);
            check("idle_q", int'(q), int'(4'b0110));
            check("idle_ps", int'(PS), 1);
        end
        run("lsr2", 2'b01, 3'd2, 4'b1011, 4'b0010, 4, 0);
        run("asr2", 2'b11, 3'd2, 4'b1011, 4'b1110, 4, 3);
        run("rol1", 2'b10, 3'd1, 4'b1011, 4'b0111, 3, 0);
        run("rol4", 2'b10, 3'd4, 4'b1011, 4'b1011, 6, 0);
        run("lsl7", 2'b00, 3'd7, 4'b1011, 4'b0000, 6, 4);
        run("asr7", 2'b11, 3'd7, 4'b1011, 4'b1111, 6, 0);
        run("amt0", 2'b01, 3'd0, 4'b1011, 4'b1011, 2, 0);
        @(negedge clk);
        op = 2'b00; amount = 3'd3; data_in = 4'b1011; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("mid_busy", int'(busy), 1);
        check("mid_ps", int'(PS), 0);
        rst = 1'b1;
        @(negedge clk);
        check("rst2_busy", int'(busy), 0);
        check("rst2_done", int'(done), 0);
        check("rst2_ps", int'(PS), 1);
        rst = 1'b0;
        ndone = 0;
        repeat (8) begin
            @(negedge clk);
            ndone += int'(done);
        end
        check("rst2_nodone", ndone, 0);
        run("post_rst", 2'b01, 3'd2, 4'b1011, 4'b0010, 4, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
